// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, alu_op codes, state encoding and opcode-class helper shared by multicycle_ctrl
package ctrl_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;
    typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_HALT, CL_NOP} op_class_t;
    function automatic op_class_t op_class(logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND: return CL_ALU;
            OP_LOAD:  return CL_LOAD;
            OP_STORE: return CL_STORE;
            OP_HALT:  return CL_HALT;
            default:  return CL_NOP;
        endcase
    endfunction
    function automatic logic [1:0] alu_sel(logic [3:0] op);
        return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_ADD;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles; ports clk, rst_n, clear, count_en, mem_ready in, timeout out
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic mem_ready,
    output logic timeout
);
    logic [7:0] count;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) count <= '0;
        else if (count_en) count <= count + 8'd1;
    end
    assign timeout = count == 8'(WAIT_MAX) && !mem_ready;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer; in clk, rst_n, run, opcode, mem_ready; out datapath strobes, alu_op, instr_done, fault, state
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_load,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       fault,
    output logic [2:0] state
);
    state_t cur;
    logic [3:0] opcode_q;
    logic timeout;
    logic waiting;
    op_class_t dcl, qcl;
    state_t after_retire;
    assign waiting = cur == ST_FETCH || cur == ST_MEM;
    assign dcl = op_class(opcode);
    assign qcl = op_class(opcode_q);
    assign after_retire = run ? ST_FETCH : ST_IDLE;
    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!waiting || mem_ready),
        .count_en  (waiting),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur      <= ST_IDLE;
            opcode_q <= '0;
        end else begin
            case (cur)
                ST_IDLE:   cur <= run ? ST_FETCH : ST_IDLE;
                ST_FETCH:  cur <= mem_ready ? ST_DECODE : timeout ? ST_FAULT : ST_FETCH;
                ST_DECODE: begin
                    opcode_q <= opcode;
                    cur <= dcl == CL_HALT ? ST_IDLE : dcl == CL_NOP ? after_retire : ST_EXEC;
                end
                ST_EXEC:   cur <= qcl == CL_ALU ? ST_WB : ST_MEM;
                ST_MEM:    cur <= mem_ready ? (qcl == CL_LOAD ? ST_WB : after_retire)
                                            : timeout ? ST_FAULT : ST_MEM;
                ST_WB:     cur <= after_retire;
                ST_FAULT:  cur <= ST_FAULT;
                default:   cur <= ST_IDLE;
            endcase
        end
    end
    assign state       = cur;
    assign pc_write    = cur == ST_FETCH && mem_ready;
    assign ir_load     = cur == ST_FETCH && mem_ready;
    assign iord        = cur == ST_MEM;
    assign mem_read    = cur == ST_FETCH || (cur == ST_MEM && qcl == CL_LOAD);
    assign mem_write   = cur == ST_MEM && qcl == CL_STORE;
    assign alu_op      = (cur == ST_EXEC || cur == ST_WB) && qcl == CL_ALU ? alu_sel(opcode_q) : ALU_ADD;
    assign alu_src_imm = cur == ST_EXEC && (qcl == CL_LOAD || qcl == CL_STORE);
    assign reg_write   = cur == ST_WB;
    assign mem_to_reg  = cur == ST_WB && qcl == CL_LOAD;
    // DECODE retires NOP/HALT off the live opcode, before opcode_q holds it
    assign instr_done  = (cur == ST_DECODE && (dcl == CL_HALT || dcl == CL_NOP))
                      || (cur == ST_MEM && qcl == CL_STORE && mem_ready)
                      || cur == ST_WB;
    assign fault       = cur == ST_FAULT;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: trace-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       pc_write, ir_load, iord, mem_read, mem_write;
        logic [1:0] alu_op;
        logic       alu_src_imm, reg_write, mem_to_reg, instr_done, fault;
        logic [2:0] state;
    } outs_t;
    typedef struct {
        logic       rst_n, run, rdy;
        logic [3:0] op;
        bit         chk;
        outs_t      e;
    } cyc_t;
    logic clk = 0, rst_n = 0, run = 0, mem_ready = 0;
    logic [3:0] opcode = 0;
    logic pc_write, ir_load, iord, mem_read, mem_write, alu_src_imm, reg_write, mem_to_reg, instr_done, fault;
    logic [1:0] alu_op;
    logic [2:0] state;
    outs_t got;
    cyc_t tr[$];
    int lat[$];
    int checks = 0, failures = 0;
    int idx = 0;
    bit valid = 0;
    int since = 0;
    logic [2:0] prev = 0;
    multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_load(ir_load), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .fault(fault), .state(state)
    );
    always #5 clk = ~clk;
    assign got = {pc_write, ir_load, iord, mem_read, mem_write, alu_op, alu_src_imm,
                  reg_write, mem_to_reg, instr_done, fault, state};
    function automatic int cls(logic [3:0] op);
        case (op)
            4'b0001, 4'b0011, 4'b0100: return 0;
            4'b0101: return 1;
            4'b0110: return 2;
            4'b1111: return 3;
            default: return 4;
        endcase
    endfunction
    function automatic outs_t st(logic [2:0] s);
        outs_t o = '0;
        o.state = s;
        return o;
    endfunction
    task automatic push(logic rn, logic r, logic rdy, logic [3:0] op, bit chk, outs_t e);
        cyc_t c;
        c.rst_n = rn; c.run = r; c.rdy = rdy; c.op = op; c.chk = chk; c.e = e;
        tr.push_back(c);
    endtask
    task automatic idle(int n, logic r);
        for (int i = 0; i < n; i++) push(1, r, 1, 4'hF, 1, st(0));
    endtask
    // one instruction: fw/mw wait cycles, r = run level after fetch, abort = reset on first MEM cycle
    task automatic instr(logic [3:0] op, int fw, int mw, logic r, bit abort);
        int c = cls(op);
        logic [1:0] a = op == 4'b0011 ? 2'b01 : op == 4'b0100 ? 2'b10 : 2'b00;
        outs_t o = st(1);
        o.mem_read = 1;
        for (int i = 0; i < fw; i++) push(1, 1, 0, 4'hF, 1, o);
        o.ir_load = 1; o.pc_write = 1;
        push(1, 1, 1, 4'hF, 1, o);
        o = st(2); o.instr_done = c >= 3;
        push(1, r, 1, op, 1, o);
        if (c >= 3) return;
        o = st(3);
        if (c == 0) o.alu_op = a; else o.alu_src_imm = 1;
        push(1, r, 1, 4'hF, 1, o);
        if (c != 0) begin
            o = st(4); o.iord = 1; o.mem_read = c == 1; o.mem_write = c == 2;
            if (abort) begin
                push(0, r, 0, 4'hF, 1, o);
                return;
            end
            for (int i = 0; i < mw; i++) push(1, r, 0, 4'hF, 1, o);
            o.instr_done = c == 2;
            push(1, r, 1, 4'hF, 1, o);
            if (c == 2) return;
        end
        o = st(5); o.reg_write = 1; o.mem_to_reg = c == 1; o.alu_op = c == 0 ? a : 2'b00; o.instr_done = 1;
        push(1, r, 1, 4'hF, 1, o);
    endtask
    always @(negedge clk) begin
        if (valid) begin
            if (tr[idx].chk) begin
                checks++;
                if (got !== tr[idx].e) begin
                    failures++;
                    $display("FAIL cycle %0d outputs: got %h expected %h (state got %0d exp %0d)",
                             idx, got, tr[idx].e, state, tr[idx].e.state);
                end
            end
            since = (state == 3'd1 && prev != 3'd1) ? 1 : since + 1;
            if (instr_done === 1'b1) lat.push_back(since);
            prev = state;
        end
    end
    initial begin
        int exp_lat[10] = '{4, 8, 5, 4, 2, 6, 2, 19, 2, 5};
        outs_t o;
        push(0, 0, 0, 4'h0, 0, st(0));
        push(0, 0, 0, 4'h0, 0, st(0));
        idle(1, 1);
        instr(4'b0001, 0, 0, 1, 0);
        instr(4'b0101, 0, 3, 1, 0);
        instr(4'b0011, 1, 0, 1, 0);
        instr(4'b0100, 0, 0, 1, 0);
        instr(4'b0010, 0, 0, 1, 0);
        instr(4'b0110, 0, 2, 0, 0);
        idle(2, 0);
        idle(1, 1);
        instr(4'b1111, 0, 0, 1, 0);
        idle(1, 1);
        instr(4'b0001, 15, 0, 1, 0);
        instr(4'b0000, 0, 0, 0, 0);
        idle(1, 1);
        instr(4'b0110, 0, 0, 1, 1);
        idle(1, 1);
        instr(4'b0101, 0, 0, 0, 0);
        idle(1, 1);
        o = st(1); o.mem_read = 1;
        for (int i = 0; i < 16; i++) push(1, 1, 0, 4'hF, 1, o);
        o = st(6); o.fault = 1;
        for (int i = 0; i < 3; i++) push(1, 1, 1, 4'hF, 1, o);
        push(0, 1, 1, 4'hF, 1, o);
        idle(1, 0);
        for (int i = 0; i < tr.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n = tr[i].rst_n; run = tr[i].run; mem_ready = tr[i].rdy; opcode = tr[i].op;
            idx = i; valid = 1;
        end
        @(negedge clk);
        #1;
        valid = 0;
        checks++;
        if (lat.size() != 10) begin
            failures++;
            $display("FAIL retire count: got %0d expected 10", lat.size());
        end
        for (int i = 0; i < 10 && i < lat.size(); i++) begin
            checks++;
            if (lat[i] != exp_lat[i]) begin
                failures++;
                $display("FAIL latency %0d: got %0d expected %0d", i, lat[i], exp_lat[i]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
